isr_nested_ctrl: RTL and testbench
==================================

// Module: isr_nested_ctrl
// PURPOSE
//  Parametrised, fully synchronous in-service register (ISR) and INTA sequencer for the PIC.
//  Sits between the priority/IRR stage and the data buffer/control logic.
//  Accepts masked pending requests and runs the two-pulse INTA sequence.
//  Sets and clears ISR bits (AEOI, specific EOI, non-specific EOI) and returns the vector.
//  Generalises the 8-level ISR to NUM_IRQ levels with nested-priority gating of the CPU request.
// PARAMETERS
//  NUM_IRQ  8                        number of interrupt levels (2..32)
//  ID_W     $clog2(NUM_IRQ)          width of a level index
//  VEC_W    8                        vector width; vector = {vec_base, id}
//  BASE_W   VEC_W-ID_W               width of the programmable vector base
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst_n        in   1        synchronous active-low reset
//  irr_req      in   NUM_IRQ  masked pending requests (bit 0 = level 0)
//  inta_pulse   in   1        one-cycle strobe per INTA pulse (already synchronised)
//  aeoi_en      in   1        automatic EOI mode (ICW4)
//  eoi_ns       in   1        one-cycle non-specific EOI command strobe
//  eoi_sp       in   1        one-cycle specific EOI command strobe
//  eoi_level    in   ID_W     level cleared by eoi_sp
//  vec_base     in   BASE_W   vector base (ICW2 upper bits)
//  isr_reg      out  NUM_IRQ  in-service register
//  int_out      out  1        interrupt request to CPU (registered)
//  irq_ack      out  NUM_IRQ  one-hot, one-cycle: level accepted, IRR stage clears its latch
//  vec_out      out  VEC_W    vector byte
//  vec_valid    out  1        one-cycle qualifier for vec_out
//  busy         out  1        high between first and second INTA
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): isr_reg=0, int_out=0, irq_ack=0, vec_out=0, vec_valid=0,
//   busy=0, state=IDLE; this applies mid-sequence and a pending AEOI clear is discarded.
//  Priority: fixed, lower index higher (see ROTATE_EN); isr_top = highest-priority set ISR bit.
//  int_out (next cycle) = 1 iff in IDLE and the highest-priority irr_req bit outranks isr_top.
//   Treat an empty ISR as ranking below all levels.
//   Equal or lower requests are held off (fully nested).
//  FSM IDLE -> WAIT2 -> IDLE.
//  IDLE + inta_pulse with a valid winner:
//   latch win_id, set isr_reg[win_id], irq_ack[win_id]=1 for 1 cycle, busy=1, int_out=0.
//   Move to WAIT2.
//  IDLE + inta_pulse without a winner (spurious): win_id=NUM_IRQ-1, no ISR set, no irq_ack.
//   Move to WAIT2.
//  WAIT2 + inta_pulse: next cycle vec_out={vec_base,win_id}, vec_valid=1 for 1 cycle, busy=0.
//   If aeoi_en, clear isr_reg[win_id] in the same edge; a spurious sequence clears nothing.
//   Move to IDLE.
//  inta_pulse in the WAIT2 exit cycle: ignored, since a new sequence starts only from IDLE.
//  eoi_ns: clear isr_top; no-op if ISR is empty.
//  eoi_sp: clear isr_reg[eoi_level]; ignored if eoi_level >= NUM_IRQ.
//  Simultaneous events on one edge: clears (EOI/AEOI) apply first, then the INTA set.
//   The set wins on the same bit.
//   eoi_ns and eoi_sp together: both clears apply.
//  Width: vec_base is not truncated; win_id is zero-extended to ID_W.
// CONFIGURATION
//  ROTATE_EN defined:
//   Adds input rot_en (1 bit) and an internal lowest-priority pointer lp (reset NUM_IRQ-1).
//   Priority order is lp+1, lp+2, ... modulo NUM_IRQ, wrapping past NUM_IRQ-1 to 0.
//   When rot_en=1, each eoi_ns or AEOI clear sets lp to the cleared level.
//   isr_top and the request winner both use the rotated order.
//  ROTATE_EN undefined: no rot_en port, no lp register, fixed priority (level 0 highest).
// TESTING
//  T1: reset, irr_req=8'h10, vec_base=5'h08, two inta_pulse
//      -> irq_ack=8'h10, isr_reg=8'h10, vec_out=8'h44, vec_valid=1 one cycle.
//  T2: isr_reg=8'h04 in service, irr_req=8'h20 -> int_out stays 0.
//      Then irr_req=8'h02 -> int_out=1 next cycle.
//  T3: aeoi_en=1, irr_req=8'h01, full INTA sequence
//      -> isr_reg=0 after 2nd INTA, vec_out={vec_base,3'd0}.
//  T4: isr_reg=8'h82, eoi_ns -> 8'h80; then eoi_sp with eoi_level=7 -> 8'h00;
//      then eoi_sp with an empty ISR -> no change.
//  T5: irr_req dropped to 0 before 1st INTA -> no irq_ack, isr unchanged, vec_out={vec_base,3'd7};
//      rst_n=0 while busy -> all outputs 0 and FSM back in IDLE next cycle.
//  T6 (ROTATE_EN): rot_en=1, service level 2 then eoi_ns
//      -> lp=2; requests 8'h06 together -> level 1 wins (order 3..7,0,1,2).

Source files
------------

// File: rtl/isr_nested_ctrl.sv
// In-service register and two-pulse INTA sequencer with nested-priority
// gating of the CPU interrupt request.
// Optional build macro: ROTATE_EN (adds rot_en input and rotating priority).
module isr_nested_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int VEC_W   = 8,
  parameter int BASE_W  = VEC_W - ID_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr_req,
  input  logic               inta_pulse,
  input  logic               aeoi_en,
  input  logic               eoi_ns,
  input  logic               eoi_sp,
  input  logic [ID_W-1:0]    eoi_level,
  input  logic [BASE_W-1:0]  vec_base,
`ifdef ROTATE_EN
  input  logic               rot_en,
`endif
  output logic [NUM_IRQ-1:0] isr_reg,
  output logic               int_out,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [VEC_W-1:0]   vec_out,
  output logic               vec_valid,
  output logic               busy
);

  localparam int unsigned N = NUM_IRQ;

  typedef enum logic {IDLE, WAIT2} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    win_id, win_d;
  logic               spur_q, spur_d;
  logic [ID_W-1:0]    lp;
  logic [NUM_IRQ-1:0] isr_d, ack_d, set_v, clr_v;
  logic [VEC_W-1:0]   vec_d;
  logic               valid_d, int_d;
  logic [ID_W:0]      req_pick, isr_pick;
`ifdef ROTATE_EN
  logic [ID_W-1:0]    lp_d;
`endif

  // Highest-priority set bit, scanning from lowp+1 upward with wrap.
  // Result MSB flags "found", low bits hold the level.
  function automatic logic [ID_W:0] pick_top(input logic [NUM_IRQ-1:0] v,
                                             input logic [ID_W-1:0]    lowp);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(lowp) + k + 1) % N);
      if (!res[ID_W] && v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Position of a level in the current priority order (0 = highest).
  function automatic logic [ID_W-1:0] rank_of(input logic [ID_W-1:0] id,
                                              input logic [ID_W-1:0] lowp);
    return ID_W'((32'(id) + N - 32'(lowp) - 1) % N);
  endfunction

`ifndef ROTATE_EN
  assign lp = ID_W'(N - 1);
`endif

  assign busy = (state_q == WAIT2);

  // Next-state, ISR update (clears first, then INTA set), vector and request.
  always_comb begin
    req_pick = pick_top(irr_req, lp);
    isr_pick = pick_top(isr_reg, lp);
    state_d  = state_q;
    win_d    = win_id;
    spur_d   = spur_q;
    vec_d    = vec_out;
    valid_d  = 1'b0;
    set_v    = '0;
    clr_v    = '0;
`ifdef ROTATE_EN
    lp_d     = lp;
`endif

    if (eoi_ns && isr_pick[ID_W]) begin
      clr_v[isr_pick[ID_W-1:0]] = 1'b1;
`ifdef ROTATE_EN
      if (rot_en) lp_d = isr_pick[ID_W-1:0];
`endif
    end
    if (eoi_sp && (32'(eoi_level) < N)) clr_v[eoi_level] = 1'b1;

    case (state_q)
      IDLE: begin
        if (inta_pulse) begin
          state_d = WAIT2;
          if (req_pick[ID_W]) begin
            win_d  = req_pick[ID_W-1:0];
            spur_d = 1'b0;
            set_v[req_pick[ID_W-1:0]] = 1'b1;
          end else begin
            win_d  = ID_W'(N - 1);
            spur_d = 1'b1;
          end
        end
      end
      WAIT2: begin
        if (inta_pulse) begin
          state_d = IDLE;
          vec_d   = {vec_base, win_id};
          valid_d = 1'b1;
          if (aeoi_en && !spur_q) begin
            clr_v[win_id] = 1'b1;
`ifdef ROTATE_EN
            if (rot_en) lp_d = win_id;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase

    isr_d = (isr_reg & ~clr_v) | set_v;
    ack_d = set_v;
    int_d = (state_q == IDLE) && !inta_pulse && req_pick[ID_W] &&
            (!isr_pick[ID_W] ||
             (rank_of(req_pick[ID_W-1:0], lp) < rank_of(isr_pick[ID_W-1:0], lp)));
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_id    <= '0;
      spur_q    <= 1'b0;
      isr_reg   <= '0;
      irq_ack   <= '0;
      int_out   <= 1'b0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
`ifdef ROTATE_EN
      lp        <= ID_W'(N - 1);
`endif
    end else begin
      state_q   <= state_d;
      win_id    <= win_d;
      spur_q    <= spur_d;
      isr_reg   <= isr_d;
      irq_ack   <= ack_d;
      int_out   <= int_d;
      vec_out   <= vec_d;
      vec_valid <= valid_d;
`ifdef ROTATE_EN
      lp        <= lp_d;
`endif
    end
  end

endmodule

// File: tb/tb_isr_nested_ctrl.sv
// Self-checking bench for isr_nested_ctrl: directed scenarios followed by
// random traffic, all checked every cycle against a behavioural model.
module tb_isr_nested_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr_req;
  logic       inta_pulse, aeoi_en, eoi_ns, eoi_sp;
  logic [2:0] eoi_level;
  logic [4:0] vec_base;
`ifdef ROTATE_EN
  logic       rot_en;
`endif
  logic [7:0] isr_reg, irq_ack, vec_out;
  logic       int_out, vec_valid, busy;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [7:0] m_isr, m_ack, m_vec;
  logic       m_int, m_valid;
  int         m_phase;   // 0: waiting for first INTA, 1: waiting for second
  int         m_win;
  bit         m_spur;
  int         m_lp;

  isr_nested_ctrl #(.NUM_IRQ(8), .VEC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .irr_req(irr_req), .inta_pulse(inta_pulse),
    .aeoi_en(aeoi_en), .eoi_ns(eoi_ns), .eoi_sp(eoi_sp), .eoi_level(eoi_level),
    .vec_base(vec_base),
`ifdef ROTATE_EN
    .rot_en(rot_en),
`endif
    .isr_reg(isr_reg), .int_out(int_out), .irq_ack(irq_ack), .vec_out(vec_out),
    .vec_valid(vec_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Rank 0 is the most urgent level; lp is the least urgent.
  function automatic int rank(input int lvl);
    return (lvl + N - m_lp - 1) % N;
  endfunction

  function automatic int top_of(input logic [7:0] v);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && (best < 0 || rank(i) < rank(best))) best = i;
    return best;
  endfunction

  task automatic model_step();
    int rq, it;
    logic [7:0] nisr;
    int nlp;
    if (!rst_n) begin
      m_isr = '0; m_ack = '0; m_vec = '0; m_int = 1'b0; m_valid = 1'b0;
      m_phase = 0; m_lp = N - 1;
      return;
    end
    rq   = top_of(irr_req);
    it   = top_of(m_isr);
    nisr = m_isr;
    nlp  = m_lp;
    m_ack   = '0;
    m_valid = 1'b0;
    m_int = (m_phase == 0) && !inta_pulse && (rq >= 0) && (it < 0 || rank(rq) < rank(it));
    if (eoi_ns && it >= 0) begin
      nisr[it] = 1'b0;
`ifdef ROTATE_EN
      if (rot_en) nlp = it;
`endif
    end
    if (eoi_sp && eoi_level < N) nisr[eoi_level] = 1'b0;
    if (m_phase == 1 && inta_pulse) begin
      m_vec   = {vec_base, 3'(m_win)};
      m_valid = 1'b1;
      if (aeoi_en && !m_spur) begin
        nisr[m_win] = 1'b0;
`ifdef ROTATE_EN
        if (rot_en) nlp = m_win;
`endif
      end
      m_phase = 0;
    end else if (m_phase == 0 && inta_pulse) begin
      if (rq >= 0) begin
        nisr[rq] = 1'b1;
        m_ack[rq] = 1'b1;
        m_win = rq;
        m_spur = 1'b0;
      end else begin
        m_win = N - 1;
        m_spur = 1'b1;
      end
      m_phase = 1;
    end
    m_isr = nisr;
    m_lp  = nlp;
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("isr_reg", 32'(isr_reg), 32'(m_isr));
    chk("int_out", 32'(int_out), 32'(m_int));
    chk("irq_ack", 32'(irq_ack), 32'(m_ack));
    chk("vec_valid", 32'(vec_valid), 32'(m_valid));
    chk("vec_out", 32'(vec_out), 32'(m_vec));
    chk("busy", 32'(busy), 32'(m_phase == 1));
  endtask

  task automatic quiet();
    inta_pulse = 1'b0; eoi_ns = 1'b0; eoi_sp = 1'b0;
  endtask

  // Full two-pulse INTA sequence with an idle cycle between pulses.
  task automatic inta_seq();
    inta_pulse = 1'b1; step();
    inta_pulse = 1'b0; step();
    inta_pulse = 1'b1; step();
    inta_pulse = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irr_req = '0; aeoi_en = 1'b0; eoi_level = '0; vec_base = 5'h08;
    quiet();
`ifdef ROTATE_EN
    rot_en = 1'b0;
`endif
    m_phase = 0; m_lp = N - 1; m_win = 0; m_spur = 1'b0;
    step(); step();
    chk("reset_isr", 32'(isr_reg), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // T1: level 4 serviced, vector {08,4} = 44
    irr_req = 8'h10; step();
    chk("t1_int", 32'(int_out), 32'h1);
    inta_pulse = 1'b1; step();
    chk("t1_ack", 32'(irq_ack), 32'h10);
    chk("t1_busy", 32'(busy), 32'h1);
    inta_pulse = 1'b0; step();
    inta_pulse = 1'b1; step();
    chk("t1_vec", 32'(vec_out), 32'h44);
    chk("t1_valid", 32'(vec_valid), 32'h1);
    chk("t1_isr", 32'(isr_reg), 32'h10);
    inta_pulse = 1'b0; irr_req = '0; step();
    chk("t1_valid_drop", 32'(vec_valid), 32'h0);

    // T2: level 2 in service holds off level 5, level 1 gets through
    eoi_sp = 1'b1; eoi_level = 3'd4; step(); quiet();
    irr_req = 8'h04; step(); inta_seq(); irr_req = 8'h20; step(); step();
    chk("t2_isr", 32'(isr_reg), 32'h04);
    chk("t2_hold", 32'(int_out), 32'h0);
    irr_req = 8'h02; step();
    chk("t2_int", 32'(int_out), 32'h1);

    // T3: AEOI on level 0
    irr_req = '0; eoi_ns = 1'b1; step(); quiet();
    aeoi_en = 1'b1; irr_req = 8'h01; step(); inta_seq();
    chk("t3_isr", 32'(isr_reg), 32'h0);
    chk("t3_vec", 32'(vec_out), 32'h40);
    aeoi_en = 1'b0; irr_req = '0; step();

    // T4: EOI clears
    irr_req = 8'h80; inta_seq(); irr_req = 8'h02; inta_seq(); irr_req = '0; step();
    chk("t4_setup", 32'(isr_reg), 32'h82);
    eoi_ns = 1'b1; step(); quiet();
    chk("t4_ns", 32'(isr_reg), 32'h80);
    eoi_sp = 1'b1; eoi_level = 3'd7; step();
    chk("t4_sp", 32'(isr_reg), 32'h00);
    step(); quiet();
    chk("t4_sp_empty", 32'(isr_reg), 32'h00);

    // T5: spurious sequence, then reset mid-sequence
    inta_pulse = 1'b1; step();
    chk("t5_ack", 32'(irq_ack), 32'h0);
    inta_pulse = 1'b0; step();
    inta_pulse = 1'b1; step();
    chk("t5_vec", 32'(vec_out), 32'h47);
    chk("t5_isr", 32'(isr_reg), 32'h0);
    irr_req = 8'h08; step(); inta_pulse = 1'b0;
    chk("t5_busy", 32'(busy), 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_isr", 32'(isr_reg), 32'h0);
    irr_req = '0; step();

`ifdef ROTATE_EN
    // T6: rotation after non-specific EOI of level 2
    rot_en = 1'b1;
    irr_req = 8'h04; inta_seq(); irr_req = '0; step();
    eoi_ns = 1'b1; step(); quiet();
    irr_req = 8'h06; step();
    inta_pulse = 1'b1; step(); inta_pulse = 1'b0;
    chk("t6_ack", 32'(irq_ack), 32'h02);
    step(); inta_pulse = 1'b1; step(); quiet(); irr_req = '0; step();
`endif

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom_range(0, 199) != 0);
      irr_req    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h1 << $urandom_range(0, 7)) & {8{$urandom_range(0, 1) == 1}};
      inta_pulse = ($urandom_range(0, 3) == 0);
      eoi_ns     = ($urandom_range(0, 7) == 0);
      eoi_sp     = ($urandom_range(0, 7) == 0);
      eoi_level  = 3'($urandom_range(0, 7));
      vec_base   = 5'($urandom);
      if (c % 200 == 0) aeoi_en = $urandom_range(0, 1) == 1;
`ifdef ROTATE_EN
      if (c % 100 == 0) rot_en = $urandom_range(0, 1) == 1;
`endif
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
